pipeline_hazard_ctrl: RTL

Stall/flush controller that drives the write-enable and bubble inputs of the PC, IF/ID and ID/EX pipeline registers. It compares the ID-stage source registers with the destination of the instruction held in ID/EX, and stalls fetch/decode on a load-use hazard. When a branch resolves taken in EX, it squashes the younger instructions. It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/pipeline_hazard_ctrl_if.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl_if
//  Purpose  : Bundles the hazard controller's ID/EX compare inputs and its
//             pipeline-register control and performance counter outputs.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic [3:0]       id_rs1;
  logic [3:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_MemRead;
  logic [3:0]       ex_RR3;
  logic             branch_taken;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       hz_state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: supplies operand/destination info, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_MemRead, ex_RR3, branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, hz_state, stall_count, flush_count
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_MemRead, ex_RR3, branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, hz_state, stall_count, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Load-use stall and taken-branch flush controller for the PC,
//             IF/ID and ID/EX registers, with saturating event counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam int c_MAX_CYC = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
  localparam int c_CNT_CW  = (c_MAX_CYC < 2) ? 1 : $clog2(c_MAX_CYC + 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_CNT_CW-1:0] r_cnt;
  logic [CNT_W-1:0]    r_stall_count;
  logic [CNT_W-1:0]    r_flush_count;

  logic w_load_use;
  logic w_branch_acc;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_bubble;

  // Register 0 is hardwired zero, so a load targeting it never hazards.
  assign w_load_use = bus.ex_MemRead && (bus.ex_RR3 != 4'd0) &&
                      ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_RR3)) ||
                       (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_RR3)));

  // Same-cycle control outputs; a branch in RUN/STALL outranks the stall.
  always_comb begin
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_branch_acc  = 1'b0;
    if (rst) begin
      case (r_state)
        S_RUN, S_STALL: begin
          if (bus.branch_taken) begin
            w_branch_acc  = 1'b1;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
          end else if ((r_state == S_STALL) || w_load_use) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
          end
        end
        S_FLUSH: begin
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State, remaining-cycle count and saturating counters, on the pipeline's negedge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_RUN;
      r_cnt         <= '0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (!w_pc_write && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_W'(1);
      if (w_branch_acc && (r_flush_count != '1))
        r_flush_count <= r_flush_count + CNT_W'(1);

      case (r_state)
        S_RUN, S_STALL: begin
          if (w_branch_acc) begin
            if (FLUSH_CYCLES > 1) begin
              r_state <= S_FLUSH;
              r_cnt   <= c_CNT_CW'(FLUSH_CYCLES - 1);
            end else begin
              r_state <= S_RUN;
              r_cnt   <= '0;
            end
          end else if (r_state == S_STALL) begin
            r_cnt <= r_cnt - c_CNT_CW'(1);
            if (r_cnt == c_CNT_CW'(1))
              r_state <= S_RUN;
          end else if (w_load_use && (STALL_CYCLES > 1)) begin
            r_state <= S_STALL;
            r_cnt   <= c_CNT_CW'(STALL_CYCLES - 1);
          end
        end
        S_FLUSH: begin
          r_cnt <= r_cnt - c_CNT_CW'(1);
          if (r_cnt == c_CNT_CW'(1))
            r_state <= S_RUN;
        end
        default: begin
          r_state <= S_RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.ifid_write  = w_ifid_write;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_bubble = w_idex_bubble;
  assign bus.hz_state    = r_state;
  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;

endmodule
`default_nettype wire
